// File: rtl/reg_write_scoreboard.sv
// reg_write_scoreboard
//   Decodes an AW-bit register address into a registered one-hot write
//   enable for the register file and tracks outstanding writes per register.
//
//   Ports:
//     gclk          rising-edge clock
//     grst          synchronous active-high reset
//     issue_valid   mark issue_addr as having a write in flight
//     issue_addr    destination register of the issued write
//     issue_ready   comb; issue accepted this cycle when high
//     commit_valid  write data for commit_addr available this cycle
//     commit_addr   register being written
//     rd_addr_a/b   source operand addresses
//     hazard_a/b    comb; operand has a pending write (registered state only)
//     we_onehot     registered one-hot load enable, one cycle after commit
//     pending       registered scoreboard
//     pend_count    registered popcount of pending
//     err           sticky; commit to a register that was not pending

// One scoreboard entry. ZERO ties the entry off for a hard-wired register.
module reg_write_scoreboard_slot #(
  parameter bit ZERO = 1'b0
) (
  input  logic gclk,
  input  logic grst,
  input  logic set,
  input  logic clr,
  output logic pend_d,
  output logic pend,
  output logic we
);
  // set wins over clr so a same-cycle issue/commit leaves the entry busy
  assign pend_d = !ZERO && (set | (pend & ~clr));

  always_ff @(posedge gclk) begin
    if (grst) begin
      pend <= 1'b0;
      we   <= 1'b0;
    end else begin
      pend <= pend_d;
      we   <= !ZERO && clr;
    end
  end
endmodule

module reg_write_scoreboard #(
  parameter int AW       = 3,
  parameter bit ZERO_REG = 1'b0,
  localparam int NREG    = 1 << AW
) (
  input  logic            gclk,
  input  logic            grst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_addr,
  output logic            issue_ready,
  input  logic            commit_valid,
  input  logic [AW-1:0]   commit_addr,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic            hazard_a,
  output logic            hazard_b,
  output logic [NREG-1:0] we_onehot,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     pend_count,
  output logic            err
);
  typedef struct packed {
    logic          vld;
    logic [AW-1:0] addr;
  } req_t;

  req_t            iss, cmt;
  logic [NREG-1:0] set_vec, clr_vec, pend_d;
  logic            err_hit;

  assign iss = '{vld: issue_valid,  addr: issue_addr};
  assign cmt = '{vld: commit_valid, addr: commit_addr};

  // With ZERO_REG the register-0 entry never goes busy, so ready stays high
  // there and the issue collapses to a no-op inside the slot.
  assign issue_ready = ~pending[iss.addr];
  assign hazard_a    = pending[rd_addr_a];
  assign hazard_b    = pending[rd_addr_b];

  // A commit to hard-wired register 0 is legal and never flags an error.
  assign err_hit = cmt.vld && !pending[cmt.addr] &&
                   !(ZERO_REG && (cmt.addr == '0));

  for (genvar i = 0; i < NREG; i++) begin : g_slot
    assign set_vec[i] = iss.vld & issue_ready & (iss.addr == AW'(i));
    assign clr_vec[i] = cmt.vld & (cmt.addr == AW'(i));

    reg_write_scoreboard_slot #(
      .ZERO (ZERO_REG && (i == 0))
    ) u_slot (
      .gclk   (gclk),
      .grst   (grst),
      .set    (set_vec[i]),
      .clr    (clr_vec[i]),
      .pend_d (pend_d[i]),
      .pend   (pending[i]),
      .we     (we_onehot[i])
    );
  end

  function automatic logic [AW:0] popcnt(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int k = 0; k < NREG; k++) c = c + (AW+1)'(v[k]);
    return c;
  endfunction

  // Count the next-state vector so the registered count tracks pending exactly.
  always_ff @(posedge gclk) begin
    if (grst) begin
      pend_count <= '0;
      err        <= 1'b0;
    end else begin
      pend_count <= popcnt(pend_d);
      err        <= err | err_hit;
    end
  end
endmodule

// File: tb/tb_reg_write_scoreboard.sv
module tb_reg_write_scoreboard;
  logic gclk = 1'b0;
  logic grst;
  always #5 gclk = ~gclk;

  // AW=3, ZERO_REG=0 instance
  logic       iv, cv;
  logic [2:0] ia, ca, ra, rb;
  logic       ir, ha, hb, er;
  logic [7:0] we, pd;
  logic [3:0] pc;

  // AW=4, ZERO_REG=1 instance
  logic        ziv, zcv;
  logic [3:0]  zia, zca, zra, zrb;
  logic        zir, zha, zhb, zer;
  logic [15:0] zwe, zpd;
  logic [4:0]  zpc;

  int checks = 0;
  int errors = 0;

  reg_write_scoreboard #(.AW(3), .ZERO_REG(1'b0)) dut (
    .gclk(gclk), .grst(grst),
    .issue_valid(iv), .issue_addr(ia), .issue_ready(ir),
    .commit_valid(cv), .commit_addr(ca),
    .rd_addr_a(ra), .rd_addr_b(rb), .hazard_a(ha), .hazard_b(hb),
    .we_onehot(we), .pending(pd), .pend_count(pc), .err(er)
  );

  reg_write_scoreboard #(.AW(4), .ZERO_REG(1'b1)) dut_z (
    .gclk(gclk), .grst(grst),
    .issue_valid(ziv), .issue_addr(zia), .issue_ready(zir),
    .commit_valid(zcv), .commit_addr(zca),
    .rd_addr_a(zra), .rd_addr_b(zrb), .hazard_a(zha), .hazard_b(zhb),
    .we_onehot(zwe), .pending(zpd), .pend_count(zpc), .err(zer)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the edge; outputs sampled there too
  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic idle();
    iv = 0; cv = 0; ia = 0; ca = 0;
    ziv = 0; zcv = 0; zia = 0; zca = 0;
  endtask

  task automatic do_reset();
    idle();
    grst = 1;
    tick();
    grst = 0;
  endtask

  initial begin
    ra = 0; rb = 0; zra = 0; zrb = 0;
    do_reset();
    chk("rst_we",    32'(we), 32'h00);
    chk("rst_pend",  32'(pd), 32'h00);
    chk("rst_cnt",   32'(pc), 32'd0);
    chk("rst_err",   32'(er), 32'd0);
    chk("rst_z_pend", 32'(zpd), 32'h0000);

    // 1: commit to a non-pending register
    cv = 1; ca = 3'd5;
    tick(); idle();
    chk("t1_we",  32'(we), 32'h20);
    chk("t1_err", 32'(er), 32'd1);
    tick();
    chk("t1_we_off", 32'(we), 32'h00);
    chk("t1_err_sticky", 32'(er), 32'd1);
    do_reset();
    chk("t1_err_clr", 32'(er), 32'd0);

    // 2: issue, hazard, commit
    iv = 1; ia = 3'd3;
    tick(); idle();
    chk("t2_pend", 32'(pd), 32'h08);
    chk("t2_cnt",  32'(pc), 32'd1);
    ia = 3'd3; ra = 3'd3;
    #1;
    chk("t2_ready", 32'(ir), 32'd0);
    chk("t2_haz",   32'(ha), 32'd1);
    cv = 1; ca = 3'd3;
    #1;
    chk("t2_haz_nobypass", 32'(ha), 32'd1);
    tick(); idle();
    chk("t2_we",     32'(we), 32'h08);
    chk("t2_pend0",  32'(pd), 32'h00);
    chk("t2_haz0",   32'(ha), 32'd0);
    chk("t2_err",    32'(er), 32'd0);

    // 3: fill and drain in reverse order
    for (int i = 0; i < 8; i++) begin
      iv = 1; ia = 3'(i);
      tick();
      chk("t3_cnt_up", 32'(pc), 32'(i + 1));
    end
    idle();
    chk("t3_full", 32'(pd), 32'hFF);
    for (int i = 7; i >= 0; i--) begin
      cv = 1; ca = 3'(i);
      tick();
      chk("t3_we", 32'(we), 32'(1 << i));
      chk("t3_cnt_dn", 32'(pc), 32'(i));
    end
    idle();
    tick();
    chk("t3_we_off", 32'(we), 32'h00);
    chk("t3_err", 32'(er), 32'd0);

    // 4: simultaneous issue/commit
    iv = 1; ia = 3'd6;
    tick(); idle();
    chk("t4_pre", 32'(pd), 32'h40);
    iv = 1; ia = 3'd2; cv = 1; ca = 3'd6;
    tick(); idle();
    chk("t4_pend_diff", 32'(pd), 32'h04);
    chk("t4_we_diff",   32'(we), 32'h40);
    chk("t4_err_diff",  32'(er), 32'd0);
    iv = 1; ia = 3'd4; cv = 1; ca = 3'd4;
    tick(); idle();
    chk("t4_pend_same", 32'(pd), 32'h14);
    chk("t4_we_same",   32'(we), 32'h10);
    chk("t4_err_same",  32'(er), 32'd1);
    chk("t4_cnt",       32'(pc), 32'd2);
    rb = 3'd2;
    #1;
    chk("t4_hazb", 32'(hb), 32'd1);
    // blocked issue leaves state unchanged
    iv = 1; ia = 3'd2;
    tick(); idle();
    chk("t4_blocked", 32'(pd), 32'h14);
    chk("t4_blk_cnt", 32'(pc), 32'd2);

    // 5: hard-wired register 0 on the AW=4 instance
    do_reset();
    zia = 4'd0; zra = 4'd0; zrb = 4'd0;
    #1;
    chk("t5_ready0", 32'(zir), 32'd1);
    ziv = 1; zia = 4'd0; zcv = 1; zca = 4'd0;
    tick(); idle();
    chk("t5_pend", 32'(zpd), 32'h0000);
    chk("t5_we",   32'(zwe), 32'h0000);
    chk("t5_err",  32'(zer), 32'd0);
    chk("t5_haza", 32'(zha), 32'd0);
    chk("t5_hazb", 32'(zhb), 32'd0);
    chk("t5_cnt",  32'(zpc), 32'd0);
    zcv = 1; zca = 4'd15;
    tick(); idle();
    chk("t5_we15",  32'(zwe), 32'h8000);
    chk("t5_err15", 32'(zer), 32'd1);

    // 6: reset discards in-flight writes
    do_reset();
    iv = 1; ia = 3'd1;
    tick();
    ia = 3'd2;
    tick(); idle();
    chk("t6_pre", 32'(pd), 32'h06);
    grst = 1; cv = 1; ca = 3'd1;
    tick(); idle(); grst = 0;
    chk("t6_pend", 32'(pd), 32'h00);
    chk("t6_cnt",  32'(pc), 32'd0);
    chk("t6_we",   32'(we), 32'h00);
    chk("t6_err",  32'(er), 32'd0);
    tick();
    chk("t6_we_after", 32'(we), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
